tpu_pingpong_buffers: RTL
=========================

# tpu_pingpong_buffers

Double-buffered operand and result storage for the systolic array, generalised to non-square ROWS×KDIM by KDIM×COLS products. Host writes into the idle A/B bank while the array reads the active bank, and banks swap on a handshake. Captured C results land in a two-entry result queue that the host drains through a registered read port with optional signed saturation. Sits between the host/CSR write path and the MAC array, replacing the single-bank A/B/C buffer.

## Interface
Parameters:
- ROWS, 4, array rows (rows of A and C)
- COLS, 4, array columns (columns of B and C)
- KDIM, 4, inner dimension (columns of A, rows of B)
- DATA_W, 8, operand element width
- SUM_W, 32, accumulator width from the array
- OUT_W, 32, host readback width, ≤ SUM_W
- SAT_OUT, 1, 1 means signed saturation to OUT_W; 0 means truncation to the low OUT_W bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- we_a  in  1  write A element into the fill bank
- addr_a  in  $clog2(ROWS*KDIM)  row-major A index
- wdata_a  in  DATA_W  A element
- we_b  in  1  write B element into the fill bank
- addr_b  in  $clog2(KDIM*COLS)  row-major B index
- wdata_b  in  DATA_W  B element
- swap_req  in  1  level request to exchange fill and active banks
- compute_busy  in  1  array is consuming the active bank
- swap_ack  out  1  one-cycle pulse on the cycle the swap occurs
- fill_bank  out  1  index of the bank the host currently writes
- a_flat  out  DATA_W*ROWS*KDIM  active-bank A, element i at [i*DATA_W +: DATA_W]
- b_flat  out  DATA_W*KDIM*COLS  active-bank B, same packing
- capture_c  in  1  latch sum_flat into the result queue
- sum_flat  in  SUM_W*ROWS*COLS  array accumulators, row-major
- c_avail  out  1  head result entry is full
- c_rd_en  in  1  read one element of the head entry
- c_rd_addr  in  $clog2(ROWS*COLS)  row-major C index
- c_rd_data  out  OUT_W  registered read data
- c_rd_valid  out  1  c_rd_data is valid this cycle
- c_release  in  1  host is done with the head entry; pop it
- c_overflow  out  1  sticky; a capture was dropped

## Operation
- A/B banks: bank 0/1 each. Writes go to the fill bank; a_flat/b_flat show the active bank (= ~fill_bank) combinationally from registers.
- Swap: when swap_req && !compute_busy, fill_bank toggles and swap_ack pulses. If compute_busy is high, the request waits; holding swap_req after the ack causes another swap next cycle.
- Writes in the swap cycle target the pre-swap fill bank.
- Swap copies no data. The new fill bank keeps its stale contents.
- Result queue: two C entries, full[1:0], write pointer wp, read pointer rp.
  - capture_c with !full[wp]: the entry is written, full[wp] is set, and wp toggles.
  - capture_c with full[wp]: the data is dropped and c_overflow is set; it clears only on reset.
- c_avail = full[rp].
- c_release with c_avail clears full[rp] and toggles rp. c_release with !c_avail is ignored.
- Simultaneous capture and release: capture evaluates the pre-release full flags. When both entries are full, the capture is dropped (overflow) and the release still pops.
- Readback: c_rd_en reads entry rp at c_rd_addr regardless of c_avail. When !c_avail, c_rd_valid stays 0 and c_rd_data holds its value.
- Width conversion: with SAT_OUT=1, a value > 2^(OUT_W-1)-1 clamps to max and a value < -2^(OUT_W-1) clamps to min. With OUT_W==SUM_W it passes through.

## Timing
- Reset values: all bank and C storage 0; fill_bank 0; wp=rp=0; full 0; swap_ack 0; c_avail 0; c_rd_valid 0; c_rd_data 0; c_overflow 0; a_flat/b_flat 0.
- Reset mid-operation discards pending swaps and all queued results.
- A/B write → visible on a_flat/b_flat only after a swap. Swap cycle N → new active bank on the flat outputs at N+1.
- capture_c at cycle N → c_avail=1 at N+1, when the queue was empty.
- c_rd_en at cycle N → c_rd_data/c_rd_valid at N+1. Back-to-back reads give one element per cycle.
- c_release at cycle N → c_avail reflects the next entry at N+1. A read issued in the release cycle returns the old entry's data.
- Out-of-range addresses: writes are ignored, reads return 0 with c_rd_valid=1.

## Structure
- Package tpu_buf_pkg holds:
  - address-width helper functions
  - a sat_trunc function, parametrised on SUM_W/OUT_W and SAT_OUT
  - localparams for the A, B and C element counts
- Sub-module tpu_bank_pair holds two register banks with a write port into sel and a flat view of ~sel. It is instantiated for A and for B.
- C queue, pointers and readback stay in the top level.

## Test plan
- ROWS=2, KDIM=3, COLS=2: write A=1..6 into bank 0, then swap_req with compute_busy=0 → swap_ack at the next edge, fill_bank=1, a_flat elements read 1..6.
- Hold compute_busy=1 for 5 cycles with swap_req=1 → no ack and fill_bank unchanged; drop busy → ack in the same cycle and toggle at the following edge.
- Capture sums 10..13, then 20..23 → c_avail=1; reading addr 2 gives 12 one cycle later; release; reading addr 2 gives 22.
- Three captures without release → third dropped, c_overflow=1, queue contents 10../20.. intact.
- Both entries full, capture and release in the same cycle → overflow set and one entry remains (c_avail=1).
- SAT_OUT=1, SUM_W=32, OUT_W=16: sums 40000, -40000 and 123 → 32767, -32768 and 123. Reset pulse afterwards → c_avail=0 and c_rd_data=0.

Source files
------------

// File: rtl/tpu_buf_pkg.sv
// Shared helpers for the ping-pong operand/result buffers: address widths,
// element counts, default geometry and the result width conversion.
package tpu_buf_pkg;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;
  localparam int DEF_KDIM = 4;

  // Width of an index into an n-element array (at least one bit).
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Element count of a row-major r x c matrix.
  function automatic int elems(input int r, input int c);
    return r * c;
  endfunction

  // Convert a sign-extended accumulator value to out_w bits. With sat set the
  // value is clamped to the signed out_w range; otherwise it is returned
  // unchanged and the caller keeps the low out_w bits (plain truncation).
  // Accumulators up to 64 bits are supported.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v,
                                                  input int sum_w,
                                                  input int out_w,
                                                  input bit sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (!sat || (out_w >= sum_w) || (out_w >= 64)) return v;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/tpu_bank_pair.sv
// Two register banks: the host writes the bank selected by sel, while the
// other bank (~sel) is presented as a flat packed vector to the array.
module tpu_bank_pair
  import tpu_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sel,
  input  logic                   we,
  input  logic [addr_w(N)-1:0]   addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W*N-1:0]    flat
);

  logic [DATA_W-1:0] bank0 [N];
  logic [DATA_W-1:0] bank1 [N];

  // Write port into the fill bank; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (we && (int'(addr) < N)) begin
      if (sel) bank1[addr] <= wdata;
      else     bank0[addr] <= wdata;
    end
  end

  // Flat view of the active bank, straight from the registers.
  always_comb begin
    flat = '0;
    for (int i = 0; i < N; i++) begin
      flat[i*DATA_W +: DATA_W] = sel ? bank0[i] : bank1[i];
    end
  end

endmodule

// File: rtl/tpu_pingpong_buffers.sv
// Double-buffered A/B operand storage plus a two-entry C result queue with a
// registered, optionally saturating host read port.
module tpu_pingpong_buffers
  import tpu_buf_pkg::*;
#(
  parameter int ROWS    = DEF_ROWS,
  parameter int COLS    = DEF_COLS,
  parameter int KDIM    = DEF_KDIM,
  parameter int DATA_W  = 8,
  parameter int SUM_W   = 32,
  parameter int OUT_W   = 32,
  parameter int SAT_OUT = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   we_a,
  input  logic [addr_w(elems(ROWS, KDIM))-1:0]   addr_a,
  input  logic [DATA_W-1:0]                      wdata_a,
  input  logic                                   we_b,
  input  logic [addr_w(elems(KDIM, COLS))-1:0]   addr_b,
  input  logic [DATA_W-1:0]                      wdata_b,
  input  logic                                   swap_req,
  input  logic                                   compute_busy,
  output logic                                   swap_ack,
  output logic                                   fill_bank,
  output logic [DATA_W*ROWS*KDIM-1:0]            a_flat,
  output logic [DATA_W*KDIM*COLS-1:0]            b_flat,
  input  logic                                   capture_c,
  input  logic [SUM_W*ROWS*COLS-1:0]             sum_flat,
  output logic                                   c_avail,
  input  logic                                   c_rd_en,
  input  logic [addr_w(elems(ROWS, COLS))-1:0]   c_rd_addr,
  output logic [OUT_W-1:0]                       c_rd_data,
  output logic                                   c_rd_valid,
  input  logic                                   c_release,
  output logic                                   c_overflow
);

  localparam int A_N = elems(ROWS, KDIM);
  localparam int B_N = elems(KDIM, COLS);
  localparam int C_N = elems(ROWS, COLS);

  logic signed [SUM_W-1:0] c_mem [2][C_N];
  logic [1:0]              full;
  logic                    wp;
  logic                    rp;

  tpu_bank_pair #(.DATA_W(DATA_W), .N(A_N)) u_bank_a (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (fill_bank),
    .we    (we_a),
    .addr  (addr_a),
    .wdata (wdata_a),
    .flat  (a_flat)
  );

  tpu_bank_pair #(.DATA_W(DATA_W), .N(B_N)) u_bank_b (
    .clk   (clk),
    .rst_n (rst_n),
    .sel   (fill_bank),
    .we    (we_b),
    .addr  (addr_b),
    .wdata (wdata_b),
    .flat  (b_flat)
  );

  // The ack is combinational so the host sees it in the cycle the swap is
  // taken; the bank select flips on the following edge.
  assign swap_ack = rst_n && swap_req && !compute_busy;
  assign c_avail  = full[rp];

  // Bank select toggles on every accepted swap; no data moves between banks.
  always_ff @(posedge clk) begin
    if (!rst_n) fill_bank <= 1'b0;
    else if (swap_ack) fill_bank <= ~fill_bank;
  end

  // Result queue: capture checks the pre-release flags, so a full queue drops
  // the capture even when a release happens in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full       <= '0;
      wp         <= 1'b0;
      rp         <= 1'b0;
      c_overflow <= 1'b0;
      for (int i = 0; i < C_N; i++) begin
        c_mem[0][i] <= '0;
        c_mem[1][i] <= '0;
      end
    end else begin
      if (capture_c) begin
        if (!full[wp]) begin
          for (int i = 0; i < C_N; i++) c_mem[wp][i] <= sum_flat[i*SUM_W +: SUM_W];
          full[wp] <= 1'b1;
          wp       <= ~wp;
        end else begin
          c_overflow <= 1'b1;
        end
      end
      if (c_release && full[rp]) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
      end
    end
  end

  // Registered readback of the head entry; data holds while nothing is queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_rd_valid <= 1'b0;
      c_rd_data  <= '0;
    end else begin
      c_rd_valid <= 1'b0;
      if (c_rd_en && full[rp]) begin
        c_rd_valid <= 1'b1;
        if (int'(c_rd_addr) < C_N)
          c_rd_data <= OUT_W'(sat_trunc(64'(c_mem[rp][c_rd_addr]), SUM_W, OUT_W, SAT_OUT != 0));
        else
          c_rd_data <= '0;
      end
    end
  end

endmodule
